ex_muldiv: RTL and testbench

//  Iterative 32-bit multiply/divide unit in the EX stage; consumes the ex_* bundle driven by the ID/EX pipeline register.

---
 rtl/ex_muldiv_pkg.sv | 38 +++
 rtl/ex_muldiv_datapath.sv | 60 ++++++
 rtl/ex_muldiv.sv | 132 +++++++++++++
 tb/tb_ex_muldiv.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op class/op codes, FSM states, widths.
// Build option: MULDIV_FAST_MUL_EN (single-cycle multiply) is consumed by ex_muldiv.
package ex_muldiv_pkg;

  localparam int WORD_W    = 32;
  localparam int OP_HIGH_W = 3;
  localparam int OP_LOW_W  = 8;
  localparam int ITER      = 32;
  localparam int CNT_W     = $clog2(ITER);

  localparam logic [WORD_W-1:0]    ZERO_WORD      = '0;
  localparam logic [OP_HIGH_W-1:0] EX_HIGH_MULDIV = 3'b101;

  localparam logic [OP_LOW_W-1:0] EX_MULDIV_MULT  = 8'h18;
  localparam logic [OP_LOW_W-1:0] EX_MULDIV_MULTU = 8'h19;
  localparam logic [OP_LOW_W-1:0] EX_MULDIV_DIV   = 8'h1A;
  localparam logic [OP_LOW_W-1:0] EX_MULDIV_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    MULDIV_IDLE = 2'd0,
    MULDIV_BUSY = 2'd1,
    MULDIV_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_valid(input logic [OP_LOW_W-1:0] op);
    return (op == EX_MULDIV_MULT) || (op == EX_MULDIV_MULTU) ||
           (op == EX_MULDIV_DIV)  || (op == EX_MULDIV_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [OP_LOW_W-1:0] op);
    return (op == EX_MULDIV_DIV) || (op == EX_MULDIV_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_LOW_W-1:0] op);
    return (op == EX_MULDIV_MULT) || (op == EX_MULDIV_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Working registers for the iterative unit: shift-add multiplier and restoring divider,
// both stepped together; the controller picks whichever result matches the latched op.
module ex_muldiv_datapath
  import ex_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  output logic [63:0]       prod_next,
  output logic [WORD_W-1:0] quot_next,
  output logic [WORD_W-1:0] rem_next
);

  logic [63:0]       acc_q;
  logic [63:0]       mcand_q;
  logic [WORD_W-1:0] mplier_q;
  logic [WORD_W-1:0] rem_q;
  logic [WORD_W-1:0] quo_q;
  logic [WORD_W-1:0] dvs_q;

  logic [WORD_W:0]   shifted;
  logic              fits;

  // The 33-bit partial remainder is the old remainder with the next dividend bit shifted in.
  always_comb begin
    prod_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    shifted   = {rem_q, quo_q[WORD_W-1]};
    fits      = (shifted >= {1'b0, dvs_q});
    rem_next  = fits ? (shifted[WORD_W-1:0] - dvs_q) : shifted[WORD_W-1:0];
    quot_next = {quo_q[WORD_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {32'd0, op_a};
      mplier_q <= op_b;
      rem_q    <= '0;
      quo_q    <= op_a;
      dvs_q    <= op_b;
    end else if (step) begin
      acc_q    <= prod_next;
      mcand_q  <= {mcand_q[62:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WORD_W-1:1]};
      rem_q    <= rem_next;
      quo_q    <= quot_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage MULT/MULTU/DIV/DIVU unit: FSM, sign handling and HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply; divide stays iterative either way.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_HIGH_W-1:0] ex_alusel,
  input  logic [OP_LOW_W-1:0]  ex_aluop,
  input  logic [WORD_W-1:0]    ex_srcLeft,
  input  logic [WORD_W-1:0]    ex_srcRight,
  input  logic                 stall_ex,
  output logic                 stallreq_ex,
  output logic                 busy,
  output logic                 hilo_we,
  output logic [WORD_W-1:0]    hi,
  output logic [WORD_W-1:0]    lo,
  output muldiv_state_e        state_dbg
);

  // Handshake with CTRL: stallreq_ex holds ID/EX while an op is accepted or iterating; in DONE,
  // stall_ex high keeps us in DONE with results held, and the op leaves only when stall_ex is low.
  muldiv_state_e state_q, state_n;

  logic              op_div, op_sgn;
  logic              start, div_zero, fast_mul, last_iter;
  logic [CNT_W-1:0]  cnt_q;
  logic              div_q, neg_res_q, neg_rem_q, first_q;
  logic [WORD_W-1:0] hi_q, lo_q;
  logic [WORD_W-1:0] a_abs, b_abs;
  logic [63:0]       prod_next, res_fix;
  logic [WORD_W-1:0] quot_next, rem_next;

  assign op_div    = op_is_div(ex_aluop);
  assign op_sgn    = op_is_signed(ex_aluop);
  assign start     = (state_q == MULDIV_IDLE) && (ex_alusel == EX_HIGH_MULDIV) && op_valid(ex_aluop);
  assign div_zero  = start && op_div && (ex_srcRight == ZERO_WORD);
  assign last_iter = (state_q == MULDIV_BUSY) && (cnt_q == CNT_W'(ITER - 1));
  assign a_abs     = (op_sgn && ex_srcLeft[WORD_W-1])  ? -ex_srcLeft  : ex_srcLeft;
  assign b_abs     = (op_sgn && ex_srcRight[WORD_W-1]) ? -ex_srcRight : ex_srcRight;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] ext_a, ext_b, prod_fast;
  assign fast_mul  = start && !op_div;
  // Low 64 bits of the product of sign/zero-extended operands are exact for both MULT and MULTU.
  assign ext_a     = op_sgn ? {{32{ex_srcLeft[WORD_W-1]}}, ex_srcLeft}  : {32'd0, ex_srcLeft};
  assign ext_b     = op_sgn ? {{32{ex_srcRight[WORD_W-1]}}, ex_srcRight} : {32'd0, ex_srcRight};
  assign prod_fast = ext_a * ext_b;
`else
  assign fast_mul  = 1'b0;
`endif

  ex_muldiv_datapath u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (start && !div_zero && !fast_mul),
    .step      (state_q == MULDIV_BUSY),
    .op_a      (a_abs),
    .op_b      (b_abs),
    .prod_next (prod_next),
    .quot_next (quot_next),
    .rem_next  (rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= MULDIV_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      MULDIV_IDLE: begin
        if (div_zero || fast_mul) state_n = MULDIV_DONE;
        else if (start)           state_n = MULDIV_BUSY;
      end
      MULDIV_BUSY: if (last_iter) state_n = MULDIV_DONE;
      MULDIV_DONE: if (!stall_ex) state_n = MULDIV_IDLE;
      default:     state_n = MULDIV_IDLE;
    endcase
  end

  always_comb begin
    stallreq_ex = start || (state_q == MULDIV_BUSY);
    busy        = (state_q != MULDIV_IDLE);
    hilo_we     = (state_q == MULDIV_DONE) && first_q;
  end

  // Magnitudes were iterated; restore signs: quotient/product by sign difference, remainder by dividend.
  always_comb begin
    if (div_q)
      res_fix = {(neg_rem_q ? -rem_next : rem_next), (neg_res_q ? -quot_next : quot_next)};
    else
      res_fix = neg_res_q ? -prod_next : prod_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      first_q   <= 1'b0;
      hi_q      <= ZERO_WORD;
      lo_q      <= ZERO_WORD;
    end else begin
      first_q <= (state_n == MULDIV_DONE) && (state_q != MULDIV_DONE);
      if (start) begin
        cnt_q     <= '0;
        div_q     <= op_div;
        neg_res_q <= op_sgn && (ex_srcLeft[WORD_W-1] ^ ex_srcRight[WORD_W-1]);
        neg_rem_q <= op_sgn && ex_srcLeft[WORD_W-1];
      end
      if (div_zero) begin
        hi_q <= ex_srcLeft;
        lo_q <= 32'hFFFF_FFFF;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (fast_mul) {hi_q, lo_q} <= prod_fast;
`endif
      if (state_q == MULDIV_BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_iter) {hi_q, lo_q} <= res_fix;
      end
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver issues ops and pushes model results, monitor pops on hilo_we.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [OP_HIGH_W-1:0] ex_alusel;
  logic [OP_LOW_W-1:0]  ex_aluop;
  logic [WORD_W-1:0]    ex_srcLeft;
  logic [WORD_W-1:0]    ex_srcRight;
  logic                 stall_ex;
  logic                 stallreq_ex;
  logic                 busy;
  logic                 hilo_we;
  logic [WORD_W-1:0]    hi;
  logic [WORD_W-1:0]    lo;
  muldiv_state_e        state_dbg;

  localparam logic [OP_HIGH_W-1:0] SEL_NOP = 3'b000;
  localparam logic [OP_HIGH_W-1:0] SEL_ALU = 3'b001;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [63:0] hold_exp;
  int          stall_cnt;
  int          n_checks;
  int          n_pass;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .ex_alusel   (ex_alusel),
    .ex_aluop    (ex_aluop),
    .ex_srcLeft  (ex_srcLeft),
    .ex_srcRight (ex_srcRight),
    .stall_ex    (stall_ex),
    .stallreq_ex (stallreq_ex),
    .busy        (busy),
    .hilo_we     (hilo_we),
    .hi          (hi),
    .lo          (lo),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    rst       = 1'b1;
    ex_alusel = SEL_NOP;
    ex_aluop  = '0;
    stall_ex  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    hold_exp = '0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    res = '0;
    if (op == EX_MULDIV_MULT) begin
      res = 64'(sa * sb);
    end else if (op == EX_MULDIV_MULTU) begin
      res = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (op == EX_MULDIV_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  function automatic int model_latency(input logic [7:0] op, input logic [31:0] b);
    if ((op == EX_MULDIV_DIV || op == EX_MULDIV_DIVU) && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (op == EX_MULDIV_MULT || op == EX_MULDIV_MULTU) return 1;
`endif
    return 33;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    ex_alusel   = EX_HIGH_MULDIV;
    ex_aluop    = op;
    ex_srcLeft  = a;
    ex_srcRight = b;
    exp_q.push_back(model(op, a, b));
    lat_q.push_back(model_latency(op, b));
  endtask

  task automatic finish(input int exp_lat, input int nstall);
    int c;
    c = 0;
    while (c < 100) begin
      @(negedge clk);
      if (hilo_we) break;
      if (c >= 1) begin
        ex_srcLeft  = $urandom;
        ex_srcRight = $urandom;
      end
      c++;
    end
    check("result_latency", 64'(c), 64'(exp_lat));
    for (int k = 0; k < nstall; k++) begin
      stall_ex = 1'b1;
      @(negedge clk);
      check("stalled_no_pulse", 64'(hilo_we), 64'(0));
      check("stalled_busy", 64'(busy), 64'(1));
    end
    stall_ex = 1'b0;
    @(posedge clk); #1;
    ex_alusel = SEL_NOP;
    ex_aluop  = '0;
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int nstall);
    issue(op, a, b);
    finish(model_latency(op, b), nstall);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [63:0] exp_v;
    int          lat_v;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else begin
        if (stallreq_ex) stall_cnt++;
        if (hilo_we) begin
          check("hilo_we_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            lat_v = lat_q.pop_front();
            check("hilo_result", {hi, lo}, exp_v);
            check("stallreq_cycles", 64'(stall_cnt), 64'(lat_v));
            hold_exp = exp_v;
          end
          stall_cnt = 0;
        end else begin
          check("hilo_hold", {hi, lo}, hold_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] ops [4];

  initial begin
    logic [31:0] a, b;
    logic [7:0]  op;
    ops[0] = EX_MULDIV_MULT;
    ops[1] = EX_MULDIV_MULTU;
    ops[2] = EX_MULDIV_DIV;
    ops[3] = EX_MULDIV_DIVU;
    n_checks    = 0;
    n_pass      = 0;
    stall_cnt   = 0;
    hold_exp    = '0;
    rst         = 1'b1;
    ex_alusel   = SEL_NOP;
    ex_aluop    = '0;
    ex_srcLeft  = '0;
    ex_srcRight = '0;
    stall_ex    = 1'b0;
    apply_reset(2);

    @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_stallreq", 64'(stallreq_ex), 64'(0));
    check("reset_hilo_we", 64'(hilo_we), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(MULDIV_IDLE));

    // Directed corner cases
    run_op(EX_MULDIV_DIVU, 32'd7, 32'd2, 0);
    run_op(EX_MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(EX_MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(EX_MULDIV_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(EX_MULDIV_DIV, 32'd5, 32'd0, 0);
    run_op(EX_MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(EX_MULDIV_MULT, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(EX_MULDIV_DIV, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(EX_MULDIV_DIVU, 32'd1000, 32'd7, 3);
    run_op(EX_MULDIV_DIVU, 32'd9, 32'd0, 2);

    // Ops outside the MULDIV class or unknown aluop must not start the unit
    @(posedge clk); #1;
    ex_alusel   = SEL_ALU;
    ex_aluop    = EX_MULDIV_DIVU;
    ex_srcLeft  = 32'd7;
    ex_srcRight = 32'd2;
    repeat (3) begin
      @(negedge clk);
      check("other_class_stallreq", 64'(stallreq_ex), 64'(0));
      check("other_class_busy", 64'(busy), 64'(0));
    end
    @(posedge clk); #1;
    ex_alusel = EX_HIGH_MULDIV;
    ex_aluop  = 8'h20;
    repeat (3) begin
      @(negedge clk);
      check("bad_op_stallreq", 64'(stallreq_ex), 64'(0));
      check("bad_op_busy", 64'(busy), 64'(0));
    end
    @(posedge clk); #1;
    ex_alusel = SEL_NOP;

    // Abort in BUSY cycle 10, then a clean op
    issue(EX_MULDIV_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    rst       = 1'b1;
    ex_alusel = SEL_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    hold_exp = '0;
    @(negedge clk);
    check("abort_state", 64'(state_dbg), 64'(MULDIV_IDLE));
    check("abort_stallreq", 64'(stallreq_ex), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hilo", {hi, lo}, 64'(0));
    run_op(EX_MULDIV_DIVU, 32'd9, 32'd3, 0);

    // Randomized ops with random DONE stalls
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
